// File: rtl/tlb_dpram.sv
// Dual-port TLB memory: port A read/write with byte enables, port B read-only,
// optional output register stage, and a clear engine that fills the array after reset or on request.
module tlb_dpram #(
  parameter int                DWIDTH  = 32,
  parameter int                AWIDTH  = 11,
  parameter int                SIZE    = 2048,
  parameter int                OREG    = 0,
  parameter int                WMODE   = 0,
  parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_wr,
  input  logic [DWIDTH/8-1:0]   a_be,
  input  logic [AWIDTH-1:0]     a_addr,
  input  logic [DWIDTH-1:0]     a_din,
  output logic [DWIDTH-1:0]     a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [AWIDTH-1:0]     b_addr,
  output logic [DWIDTH-1:0]     b_dout,
  output logic                  b_valid,
  input  logic                  clr_req,
  output logic                  busy
);
  localparam int                NB     = DWIDTH / 8;
  localparam int                IW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AWIDTH:0]   W_SIZE = (AWIDTH + 1)'(SIZE);
  localparam logic [AWIDTH-1:0] W_LAST = AWIDTH'(SIZE - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [AWIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic                w_clr_we;
  logic [DWIDTH-1:0]   r_mem [SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_cnt == W_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  logic              w_run;
  logic              w_a_inr, w_b_inr;
  logic [IW-1:0]     w_a_idx, w_b_idx;
  logic [DWIDTH-1:0] w_a_old, w_a_mrg, w_a_rd, w_b_rd;
  logic              w_a_acc, w_a_we, w_a_v, w_b_v;

  assign busy    = (r_state == S_CLEAR);
  assign w_run   = (r_state == S_RUN);
  assign w_a_inr = ({1'b0, a_addr} < W_SIZE);
  assign w_b_inr = ({1'b0, b_addr} < W_SIZE);
  assign w_a_idx = a_addr[IW-1:0];
  assign w_b_idx = b_addr[IW-1:0];
  // Out-of-range addresses read as zero rather than aliasing onto real words.
  assign w_a_old = w_a_inr ? r_mem[w_a_idx] : '0;
  assign w_b_rd  = w_b_inr ? r_mem[w_b_idx] : '0;

  always_comb begin
    w_a_mrg = w_a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) w_a_mrg[8*i +: 8] = a_din[8*i +: 8];
    end
  end

  assign w_a_acc = w_run & a_en;
  assign w_a_we  = w_a_acc & a_wr & w_a_inr;
  assign w_a_rd  = (a_wr && (WMODE == 1) && w_a_inr) ? w_a_mrg : w_a_old;
  assign w_a_v   = w_a_acc & (~a_wr | (WMODE != 2));
  assign w_b_v   = w_run & b_en;

  // Nonblocking write keeps port B on the old word during a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we)    r_mem[r_cnt[IW-1:0]] <= CLR_VAL;
      else if (w_a_we) r_mem[w_a_idx]       <= w_a_mrg;
    end
  end

  logic [DWIDTH-1:0] r_a_d1, r_b_d1;
  logic              r_a_v1, r_b_v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_d1 <= '0;
      r_b_d1 <= '0;
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
    end else begin
      r_a_v1 <= w_a_v;
      r_b_v1 <= w_b_v;
      if (w_a_v) r_a_d1 <= w_a_rd;
      if (w_b_v) r_b_d1 <= w_b_rd;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DWIDTH-1:0] r_a_d2, r_b_d2;
      logic              r_a_v2, r_b_v2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_d2 <= '0;
          r_b_d2 <= '0;
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) r_a_d2 <= r_a_d1;
          if (r_b_v1) r_b_d2 <= r_b_d1;
        end
      end
      assign a_dout  = r_a_d2;
      assign a_valid = r_a_v2;
      assign b_dout  = r_b_d2;
      assign b_valid = r_b_v2;
    end else begin : g_noreg
      assign a_dout  = r_a_d1;
      assign a_valid = r_a_v1;
      assign b_dout  = r_b_d1;
      assign b_valid = r_b_v1;
    end
  endgenerate

endmodule

// File: tb/tb_tlb_dpram.sv
// Bench for tlb_dpram: three instances (WMODE 0/OREG 0, WMODE 1/OREG 1, WMODE 2/OREG 0)
// share one stimulus stream; a reference array feeds per-port expectation queues.
module tb_tlb_dpram;
  localparam int          SIZE = 16;
  localparam logic [31:0] CV   = 32'h5A5A_A5A5;

  typedef struct {
    logic [31:0] d;
    int          due;
  } item_t;

  logic        clk, rst, a_en, a_wr, b_en, clr_req;
  logic [3:0]  a_be;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_din;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          clr_left = 0;
  logic        exp_busy = 1'b1;
  logic        mon_on = 1'b0;
  logic        rst_q = 1'b0;
  logic [31:0] mdl [SIZE];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] a_dout, b_dout, la, lb;
    logic        a_valid, b_valid, busy, late;
    item_t       qa[$], qb[$];
    item_t       it;

    tlb_dpram #(.DWIDTH(32), .AWIDTH(5), .SIZE(SIZE), .OREG(g == 1 ? 1 : 0),
                .WMODE(g), .CLR_VAL(CV)) u_dut (
      .clk(clk), .rst(rst), .a_en(a_en), .a_wr(a_wr), .a_be(a_be),
      .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
      .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
      .clr_req(clr_req), .busy(busy));

    always @(negedge clk) begin
      if (mon_on) begin
        if (rst_q) begin
          la = '0;
          lb = '0;
        end
        checks++;
        assert (busy === exp_busy) else begin
          errors++; $error("FAIL busy dut%0d cyc %0d got %b want %b", g, cyc, busy, exp_busy);
        end
        if (a_valid) begin
          checks++;
          assert (qa.size() != 0) else begin
            errors++; $error("FAIL a_unexpected dut%0d cyc %0d got %h want no valid", g, cyc, a_dout);
          end
          if (qa.size() != 0) begin
            it = qa.pop_front();
            checks += 2;
            assert (a_dout === it.d) else begin
              errors++; $error("FAIL a_data dut%0d cyc %0d got %h want %h", g, cyc, a_dout, it.d);
            end
            assert (cyc === it.due) else begin
              errors++; $error("FAIL a_latency dut%0d got cyc %0d want cyc %0d", g, cyc, it.due);
            end
          end
          la = a_dout;
        end else begin
          checks += 2;
          assert (a_dout === la) else begin
            errors++; $error("FAIL a_hold dut%0d cyc %0d got %h want %h", g, cyc, a_dout, la);
          end
          late = (qa.size() != 0) && (qa[0].due <= cyc);
          assert (!late) else begin
            errors++; $error("FAIL a_missing dut%0d cyc %0d got no valid want %h", g, cyc, qa[0].d);
            void'(qa.pop_front());
          end
        end
        if (b_valid) begin
          checks++;
          assert (qb.size() != 0) else begin
            errors++; $error("FAIL b_unexpected dut%0d cyc %0d got %h want no valid", g, cyc, b_dout);
          end
          if (qb.size() != 0) begin
            it = qb.pop_front();
            checks += 2;
            assert (b_dout === it.d) else begin
              errors++; $error("FAIL b_data dut%0d cyc %0d got %h want %h", g, cyc, b_dout, it.d);
            end
            assert (cyc === it.due) else begin
              errors++; $error("FAIL b_latency dut%0d got cyc %0d want cyc %0d", g, cyc, it.due);
            end
          end
          lb = b_dout;
        end else begin
          checks += 2;
          assert (b_dout === lb) else begin
            errors++; $error("FAIL b_hold dut%0d cyc %0d got %h want %h", g, cyc, b_dout, lb);
          end
          late = (qb.size() != 0) && (qb[0].due <= cyc);
          assert (!late) else begin
            errors++; $error("FAIL b_missing dut%0d cyc %0d got no valid want %h", g, cyc, qb[0].d);
            void'(qb.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a < 5'd16) ? mdl[a[3:0]] : 32'h0;
  endfunction

  // One clock cycle of stimulus; expectations are queued only if the model says the access is taken.
  task automatic step(input bit ra, input bit ea, input bit wa, input logic [3:0] be,
                      input logic [4:0] aa, input logic [31:0] din,
                      input bit eb, input logic [4:0] ab, input bit clr);
    logic [31:0] old, mrg, bold;
    bit          acc;
    rst = ra; a_en = ea; a_wr = wa; a_be = be; a_addr = aa; a_din = din;
    b_en = eb; b_addr = ab; clr_req = clr;
    acc = !exp_busy && !ra;
    if (acc && eb) begin
      bold = rd(ab);
      g_dut[0].qb.push_back('{bold, cyc + 1});
      g_dut[1].qb.push_back('{bold, cyc + 2});
      g_dut[2].qb.push_back('{bold, cyc + 1});
    end
    if (acc && ea) begin
      old = rd(aa);
      mrg = old;
      for (int i = 0; i < 4; i++) if (be[i]) mrg[8*i +: 8] = din[8*i +: 8];
      g_dut[0].qa.push_back('{old, cyc + 1});
      g_dut[1].qa.push_back('{(wa && aa < 5'd16) ? mrg : old, cyc + 2});
      if (!wa) g_dut[2].qa.push_back('{old, cyc + 1});
      if (wa && aa < 5'd16) mdl[aa[3:0]] = mrg;
    end
    @(posedge clk);
    #1;
    if (ra || (clr && acc)) begin
      clr_left = SIZE;
      for (int i = 0; i < SIZE; i++) mdl[i] = CV;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    exp_busy = (clr_left > 0);
  endtask

  initial begin
    rst = 1'b1; a_en = 0; a_wr = 0; a_be = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_addr = 0; clr_req = 0;
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    mon_on = 1'b1;
    repeat (SIZE) step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < SIZE; i++) step(0, 1, 0, 4'h0, 5'(i), 0, 1, 5'(i), 0);

    step(0, 1, 1, 4'hF, 5, 32'hAABB_CCDD, 0, 0, 0);
    step(0, 1, 1, 4'h5, 5, 32'h1122_3344, 0, 0, 0);
    step(0, 1, 0, 4'h0, 5, 0, 1, 5, 0);
    step(0, 1, 1, 4'h0, 5, 32'hFFFF_FFFF, 1, 5, 0);
    step(0, 1, 0, 4'h0, 5, 0, 1, 5, 0);

    step(0, 1, 1, 4'hF, 3, 32'h1, 0, 0, 0);
    step(0, 1, 1, 4'hF, 3, 32'h2, 0, 0, 0);
    step(0, 1, 0, 4'h0, 3, 0, 1, 3, 0);

    step(0, 1, 1, 4'hF, 7, 32'h5, 0, 0, 0);
    step(0, 1, 1, 4'hF, 7, 32'h9, 1, 7, 0);
    step(0, 0, 0, 4'h0, 0, 0, 1, 7, 0);

    for (int i = 0; i < SIZE; i++)
      step(0, 1, 1, 4'hF, 5'(i), (32'(i) * 32'h0101_0101) ^ 32'h00FF_00FF, 1, 5'((i + 15) % SIZE), 0);
    step(0, 1, 0, 4'h0, 4, 0, 1, 9, 0);
    step(0, 1, 0, 4'h0, 2, 0, 1, 3, 1);
    for (int i = 0; i < SIZE; i++) step(0, 1, 1, 4'hF, 5'(i), 32'hDEAD_BEEF, 1, 5'(i), i == 4);
    for (int i = 0; i < SIZE; i++) step(0, 1, 0, 4'h0, 5'(i), 0, 1, 5'((i + 8) % SIZE), 0);

    step(0, 1, 1, 4'hF, 1, 32'h0BAD_F00D, 0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    repeat (SIZE) step(0, 1, 0, 4'h0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 4'h0, 1, 0, 1, 15, 0);
    step(0, 1, 1, 4'hF, 1, 32'h1234_5678, 0, 0, 0);
    step(0, 1, 1, 4'hF, 17, 32'hFFFF_0000, 0, 0, 0);
    step(0, 1, 0, 4'h0, 16, 0, 1, 16, 0);
    step(0, 1, 0, 4'h0, 1, 0, 1, 17, 0);
    repeat (3) step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);

    checks += 6;
    assert (g_dut[0].qa.size() == 0) else begin errors++; $error("FAIL drain_a dut0 got %0d want 0", g_dut[0].qa.size()); end
    assert (g_dut[1].qa.size() == 0) else begin errors++; $error("FAIL drain_a dut1 got %0d want 0", g_dut[1].qa.size()); end
    assert (g_dut[2].qa.size() == 0) else begin errors++; $error("FAIL drain_a dut2 got %0d want 0", g_dut[2].qa.size()); end
    assert (g_dut[0].qb.size() == 0) else begin errors++; $error("FAIL drain_b dut0 got %0d want 0", g_dut[0].qb.size()); end
    assert (g_dut[1].qb.size() == 0) else begin errors++; $error("FAIL drain_b dut1 got %0d want 0", g_dut[1].qb.size()); end
    assert (g_dut[2].qb.size() == 0) else begin errors++; $error("FAIL drain_b dut2 got %0d want 0", g_dut[2].qb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
